// File: rtl/wb_mcu_bram_arbiter.sv
// wb_mcu_bram_arbiter
//
// Shares the single Wishbone port of the MCU mailbox block-RAM between two
// classic-cycle masters. Only one transaction runs per grant. Ties are broken
// round-robin. A watchdog turns a missing slave ack into an error pulse.
//
// Ports:
//   clk_i, resetn          clock, asynchronous active-low reset
//   m{0,1}_cyc_i/stb_i/we_i/adr_i/dat_i/sel_i
//                          master requests
//   m{0,1}_dat_o/ack_o/err_o
//                          read data (always s_dat_i), ack, watchdog abort
//   s_cyc_o/stb_o/we_o/adr_o/dat_o/sel_o, s_dat_i, s_ack_i
//                          RAM-side Wishbone port
//   grant_o                one-hot current grant, 2'b00 when idle
module wb_mcu_bram_arbiter #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                  clk_i,
    input  logic                  resetn,

    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_adr_i,
    input  logic [DATA_WIDTH-1:0] m0_dat_i,
    input  logic [1:0]            m0_sel_i,
    output logic [DATA_WIDTH-1:0] m0_dat_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,

    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_adr_i,
    input  logic [DATA_WIDTH-1:0] m1_dat_i,
    input  logic [1:0]            m1_sel_i,
    output logic [DATA_WIDTH-1:0] m1_dat_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,

    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [ADDR_WIDTH-1:0] s_adr_o,
    output logic [DATA_WIDTH-1:0] s_dat_o,
    output logic [1:0]            s_sel_o,
    input  logic [DATA_WIDTH-1:0] s_dat_i,
    input  logic                  s_ack_i,

    output logic [1:0]            grant_o
);

    // Encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBus0 = 2'b01,
        StBus1 = 2'b10
    } state_e;

    state_e      state_q;
    logic        last_q;    // master served most recently
    logic [7:0]  wdog_q;    // cycles spent in the current grant without ack

    logic req0;
    logic req1;
    logic wdog_hit;

    assign req0     = m0_cyc_i & m0_stb_i;
    assign req1     = m1_cyc_i & m1_stb_i;
    assign wdog_hit = (wdog_q == 8'(TIMEOUT - 1));

    assign grant_o  = state_q;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    // Slave mux and ack/err routing; everything is quiet while idle.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        unique case (state_q)
            StBus0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                m0_ack_o = s_ack_i;
                // Ack beats timeout; an aborting master gets no error.
                m0_err_o = m0_cyc_i & ~s_ack_i & wdog_hit;
            end
            StBus1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                m1_ack_o = s_ack_i;
                m1_err_o = m1_cyc_i & ~s_ack_i & wdog_hit;
            end
            default: ;
        endcase
    end

    // Every grant ends in StIdle, which guarantees the RAM sees stb drop for
    // at least one cycle before the next transaction.
    always_ff @(posedge clk_i or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            wdog_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    wdog_q <= '0;
                    if (req0 && (!req1 || last_q)) begin
                        state_q <= StBus0;
                    end else if (req1) begin
                        state_q <= StBus1;
                    end
                end
                StBus0: begin
                    if (s_ack_i || !m0_cyc_i || wdog_hit) begin
                        state_q <= StIdle;
                        last_q  <= 1'b0;
                        wdog_q  <= '0;
                    end else begin
                        wdog_q <= wdog_q + 8'd1;
                    end
                end
                StBus1: begin
                    if (s_ack_i || !m1_cyc_i || wdog_hit) begin
                        state_q <= StIdle;
                        last_q  <= 1'b1;
                        wdog_q  <= '0;
                    end else begin
                        wdog_q <= wdog_q + 8'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_mcu_bram_arbiter.sv
module tb_wb_mcu_bram_arbiter;

    localparam int AW = 12;
    localparam int DW = 16;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          m_cyc [2];
    logic          m_stb [2];
    logic          m_we  [2];
    logic [AW-1:0] m_adr [2];
    logic [DW-1:0] m_wdat[2];
    logic [1:0]    m_sel [2];
    logic [DW-1:0] m_rdat[2];
    logic          m_ack [2];
    logic          m_err [2];
    logic          s_cyc, s_stb, s_we;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_wdat;
    logic [1:0]    s_sel;
    logic [DW-1:0] s_rdat;
    logic          s_ack;
    logic [1:0]    grant;

    int n_checks = 0;
    int n_fail   = 0;

    // Slave RAM behaviour knobs, driven from the test sequence.
    bit slave_en   = 1'b1;
    bit slave_rand = 1'b0;
    bit force_ack  = 1'b0;
    logic          ack_q;
    logic [DW-1:0] mem [4096];
    logic [DW-1:0] ref_mem [4096];

    always #5 clk = ~clk;

    wb_mcu_bram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk_i(clk), .resetn(resetn),
        .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]), .m0_adr_i(m_adr[0]),
        .m0_dat_i(m_wdat[0]), .m0_sel_i(m_sel[0]), .m0_dat_o(m_rdat[0]), .m0_ack_o(m_ack[0]),
        .m0_err_o(m_err[0]),
        .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]), .m1_adr_i(m_adr[1]),
        .m1_dat_i(m_wdat[1]), .m1_sel_i(m_sel[1]), .m1_dat_o(m_rdat[1]), .m1_ack_o(m_ack[1]),
        .m1_err_o(m_err[1]),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr), .s_dat_o(s_wdat),
        .s_sel_o(s_sel), .s_dat_i(s_rdat), .s_ack_i(s_ack), .grant_o(grant)
    );

    // RAM model: acks one cycle after cyc&stb, never twice in a row.
    assign s_ack  = ack_q | force_ack;
    assign s_rdat = mem[s_adr];

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ack_q <= 1'b0;
            for (int k = 0; k < 4096; k++) mem[k] <= '0;
        end else begin
            if (ack_q && s_we) begin
                if (s_sel[0]) mem[s_adr][7:0]  <= s_wdat[7:0];
                if (s_sel[1]) mem[s_adr][15:8] <= s_wdat[15:8];
            end
            ack_q <= slave_en && s_cyc && s_stb && !ack_q &&
                     (!slave_rand || ($urandom_range(3, 0) != 0));
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_masters();
        for (int i = 0; i < 2; i++) begin
            m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_we[i] = 1'b0;
            m_adr[i] = '0;   m_wdat[i] = '0;  m_sel[i] = '0;
        end
    endtask

    task automatic start_req(input int i, input bit we, input logic [AW-1:0] adr,
                             input logic [DW-1:0] dat, input logic [1:0] sel);
        m_cyc[i] = 1'b1; m_stb[i] = 1'b1; m_we[i] = we;
        m_adr[i] = adr;  m_wdat[i] = dat; m_sel[i] = sel;
    endtask

    task automatic test_reset();
        logic [58:0] outs;
        clear_masters();
        slave_en = 1'b1; slave_rand = 1'b0; force_ack = 1'b0;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        outs = {grant, s_cyc, s_stb, s_we, s_adr, s_wdat, s_sel,
                m_ack[0], m_ack[1], m_err[0], m_err[1], m_rdat[0] & 16'h0};
        n_checks++;
        if (outs !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h, want 0", outs);
        end
        resetn = 1'b1;
        slave_en = 1'b0;
        next_cycle();
        start_req(0, 1'b0, 12'h005, 16'h0, 2'b11);
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (grant !== 2'b01 || s_stb !== 1'b1) begin
            n_fail++; $display("FAIL reset_pre_grant: grant=%b stb=%b, want 01/1", grant, s_stb);
        end
        #2 resetn = 1'b0;
        #1;
        n_checks++;
        if ({grant, s_cyc, s_stb, m_ack[0], m_err[0], m_ack[1], m_err[1]} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_async: grant=%b cyc=%b stb=%b ack0=%b err0=%b, want all 0",
                     grant, s_cyc, s_stb, m_ack[0], m_err[0]);
        end
        start_req(1, 1'b0, 12'h006, 16'h0, 2'b11);
        @(posedge clk);
        #1 resetn = 1'b1;
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (grant !== 2'b01) begin
            n_fail++; $display("FAIL reset_first_tie: grant=%b, want 01", grant);
        end
        next_cycle();
        clear_masters();
        slave_en = 1'b1;
        next_cycle();
        next_cycle();
    endtask

    task automatic test_single_write();
        start_req(0, 1'b1, 12'h010, 16'hBEEF, 2'b11);
        @(negedge clk);
        n_checks++;
        if (grant !== 2'b00) begin
            n_fail++; $display("FAIL write_cycle0_grant: grant=%b, want 00", grant);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if ({s_cyc, s_stb, s_we, s_adr, s_wdat, s_sel, m_ack[0]} !==
            {1'b1, 1'b1, 1'b1, 12'h010, 16'hBEEF, 2'b11, 1'b0}) begin
            n_fail++;
            $display("FAIL write_mirror: cyc=%b stb=%b we=%b adr=%h dat=%h sel=%b ack=%b, want 1 1 1 010 beef 11 0",
                     s_cyc, s_stb, s_we, s_adr, s_wdat, s_sel, m_ack[0]);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (m_ack[0] !== 1'b1 || m_ack[1] !== 1'b0) begin
            n_fail++; $display("FAIL write_ack: ack0=%b ack1=%b, want 1/0", m_ack[0], m_ack[1]);
        end
        next_cycle();
        clear_masters();
        start_req(1, 1'b0, 12'h010, 16'h0, 2'b11);
        @(negedge clk);
        n_checks++;
        if (grant !== 2'b00) begin
            n_fail++; $display("FAIL write_idle_gap: grant=%b, want 00", grant);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (grant !== 2'b10) begin
            n_fail++; $display("FAIL read_grant: grant=%b, want 10", grant);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (m_ack[1] !== 1'b1 || m_rdat[1] !== 16'hBEEF) begin
            n_fail++; $display("FAIL read_data: ack1=%b dat=%h, want 1/beef", m_ack[1], m_rdat[1]);
        end
        next_cycle();
        clear_masters();
        next_cycle();
    endtask

    task automatic test_contention();
        logic [1:0] exp_seq [12];
        int acks [2];
        exp_seq = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10,
                    2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10};
        acks[0] = 0; acks[1] = 0;
        start_req(0, 1'b1, 12'h020, 16'h1234, 2'b11);
        start_req(1, 1'b0, 12'h010, 16'h0, 2'b11);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            n_checks++;
            if (grant !== exp_seq[c]) begin
                n_fail++; $display("FAIL contention_grant[%0d]: grant=%b, want %b", c, grant, exp_seq[c]);
            end
            if (m_ack[0] === 1'b1) acks[0]++;
            if (m_ack[1] === 1'b1) begin
                acks[1]++;
                n_checks++;
                if (m_rdat[1] !== 16'hBEEF) begin
                    n_fail++; $display("FAIL contention_rdata: dat=%h, want beef", m_rdat[1]);
                end
            end
            next_cycle();
        end
        n_checks++;
        if (acks[0] != 2 || acks[1] != 2) begin
            n_fail++; $display("FAIL contention_acks: m0=%0d m1=%0d, want 2/2", acks[0], acks[1]);
        end
        clear_masters();
        next_cycle();
    endtask

    task automatic test_abort();
        start_req(1, 1'b0, 12'h040, 16'h0, 2'b11);
        next_cycle();
        m_cyc[1] = 1'b0;
        start_req(0, 1'b1, 12'h030, 16'h5A5A, 2'b01);
        @(negedge clk);
        n_checks++;
        if (grant !== 2'b10 || m_ack[1] !== 1'b0 || m_err[1] !== 1'b0) begin
            n_fail++; $display("FAIL abort_cycle1: grant=%b ack1=%b err1=%b, want 10/0/0", grant, m_ack[1], m_err[1]);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (grant !== 2'b00 || m_ack[1] !== 1'b0 || m_err[1] !== 1'b0) begin
            n_fail++; $display("FAIL abort_idle: grant=%b ack1=%b err1=%b, want 00/0/0", grant, m_ack[1], m_err[1]);
        end
        m_stb[1] = 1'b0;
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (grant !== 2'b01) begin
            n_fail++; $display("FAIL abort_next_grant: grant=%b, want 01", grant);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (m_ack[0] !== 1'b1) begin
            n_fail++; $display("FAIL abort_m0_ack: ack0=%b, want 1", m_ack[0]);
        end
        next_cycle();
        clear_masters();
        next_cycle();
    endtask

    task automatic test_timeout(input bit collide);
        slave_en = 1'b0;
        start_req(0, 1'b0, 12'h050, 16'h0, 2'b11);
        for (int c = 1; c <= 16; c++) begin
            next_cycle();
            force_ack = collide && (c == TO);
            @(negedge clk);
            n_checks++;
            if (collide && c == TO) begin
                if (m_ack[0] !== 1'b1 || m_err[0] !== 1'b0) begin
                    n_fail++; $display("FAIL collision: ack0=%b err0=%b, want 1/0", m_ack[0], m_err[0]);
                end
            end else if (c <= TO) begin
                if (grant !== 2'b01 || m_err[0] !== (c == TO) || m_ack[0] !== 1'b0 || m_err[1] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL timeout_cycle[%0d]: grant=%b err0=%b ack0=%b err1=%b, want 01/%0d/0/0",
                             c, grant, m_err[0], m_ack[0], m_err[1], (c == TO));
                end
            end else begin
                if (grant !== 2'b00 || s_stb !== 1'b0 || m_err[0] !== 1'b0) begin
                    n_fail++; $display("FAIL timeout_release: grant=%b stb=%b err0=%b, want 00/0/0", grant, s_stb, m_err[0]);
                end
            end
        end
        force_ack = 1'b0;
        next_cycle();
        clear_masters();
        next_cycle();
        next_cycle();
        slave_en = 1'b1;
    endtask

    // Randomized traffic against a transaction-level model: who owns the bus,
    // how many cycles it has held it, and what the RAM should contain.
    task automatic test_random();
        int owner, age, last, pick;
        bit busy [2];
        bit done [2];
        bit exp_ack [2];
        bit exp_err [2];
        logic [1:0] exp_grant;
        logic [36:0] exp_bus, got_bus;
        bit r0, r1;
        clear_masters();
        resetn = 1'b0;
        for (int k = 0; k < 4096; k++) ref_mem[k] = '0;
        next_cycle();
        resetn = 1'b1;
        slave_en = 1'b1; slave_rand = 1'b1;
        owner = -1; age = 0; last = 1;
        busy = '{0, 0}; done = '{0, 0};
        for (int n = 0; n < 3000; n++) begin
            next_cycle();
            for (int i = 0; i < 2; i++) begin
                if (busy[i] && (done[i] || $urandom_range(79, 0) == 0)) begin
                    m_cyc[i] = 0; m_stb[i] = 0; m_we[i] = 0; m_adr[i] = '0; m_wdat[i] = '0; m_sel[i] = '0;
                    busy[i] = 0;
                end else if (!busy[i] && $urandom_range(2, 0) == 0) begin
                    start_req(i, 1'($urandom_range(1, 0)), 12'($urandom_range(63, 0)),
                              16'($urandom), 2'($urandom_range(3, 1)));
                    busy[i] = 1;
                end
            end
            if ($urandom_range(39, 0) == 0) slave_en = !slave_en;
            @(negedge clk);
            exp_grant = (owner < 0) ? 2'b00 : 2'(1 << owner);
            exp_ack = '{0, 0}; exp_err = '{0, 0};
            exp_bus = '0;
            if (owner >= 0) begin
                exp_ack[owner] = s_ack;
                exp_err[owner] = !s_ack && m_cyc[owner] && (age == TO);
                exp_bus = {m_cyc[owner], m_stb[owner], m_we[owner], m_adr[owner],
                           m_wdat[owner], m_sel[owner]};
            end
            got_bus = {s_cyc, s_stb, s_we, s_adr, s_wdat, s_sel};
            n_checks += 4;
            if (grant !== exp_grant) begin
                n_fail++; $display("FAIL rand_grant @%0d: grant=%b, want %b", n, grant, exp_grant);
            end
            if ({m_ack[0], m_ack[1]} !== {exp_ack[0], exp_ack[1]}) begin
                n_fail++; $display("FAIL rand_ack @%0d: ack=%b%b, want %b%b", n, m_ack[0], m_ack[1], exp_ack[0], exp_ack[1]);
            end
            if ({m_err[0], m_err[1]} !== {exp_err[0], exp_err[1]}) begin
                n_fail++; $display("FAIL rand_err @%0d: err=%b%b, want %b%b", n, m_err[0], m_err[1], exp_err[0], exp_err[1]);
            end
            if (got_bus !== exp_bus) begin
                n_fail++; $display("FAIL rand_slave_bus @%0d: bus=%h, want %h", n, got_bus, exp_bus);
            end
            if (owner >= 0 && s_ack) begin
                if (m_we[owner]) begin
                    if (m_sel[owner][0]) ref_mem[m_adr[owner]][7:0]  = m_wdat[owner][7:0];
                    if (m_sel[owner][1]) ref_mem[m_adr[owner]][15:8] = m_wdat[owner][15:8];
                end else begin
                    n_checks++;
                    if (m_rdat[owner] !== ref_mem[m_adr[owner]]) begin
                        n_fail++; $display("FAIL rand_rdata @%0d: m%0d dat=%h, want %h",
                                           n, owner, m_rdat[owner], ref_mem[m_adr[owner]]);
                    end
                end
            end
            for (int i = 0; i < 2; i++) done[i] = (m_ack[i] === 1'b1) || (m_err[i] === 1'b1);
            if (owner < 0) begin
                r0 = m_cyc[0] && m_stb[0];
                r1 = m_cyc[1] && m_stb[1];
                pick = (r0 && r1) ? (1 - last) : (r0 ? 0 : (r1 ? 1 : -1));
                if (pick >= 0) begin
                    owner = pick; age = 1;
                end
            end else if (s_ack || !m_cyc[owner] || age == TO) begin
                last = owner; owner = -1;
            end else begin
                age++;
            end
        end
        slave_rand = 1'b0;
        clear_masters();
    endtask

    initial begin
        clear_masters();
        test_reset();
        test_single_write();
        test_contention();
        test_abort();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
